// File: rtl/pix_capture.sv
// pix_capture
//   Pixel stream sink with CPU-visible capture buffer. Accepts 8-bit pixels,
//   packs four per 32-bit word (little-endian) into an internal buffer and
//   exposes control, status, pixel count, optional checksum and the buffer
//   over the native mem_* bus.
//
//   Optional feature macro: PIX_CAPTURE_CKSUM_EN
//     defined   -> CKSUM register holds the mod-2^32 sum of captured pixels
//     undefined -> no checksum logic, CKSUM reads 0
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   in_data/in_valid     pixel stream input
//   in_ready             sink ready (1 every cycle after reset release)
//   mem_valid/mem_addr   CPU request and byte address
//   mem_wdata/mem_wstrb  write data and byte strobes (wstrb==0 means read)
//   mem_ready/mem_rdata  one-cycle acknowledge and read data
//
// States
//   IDLE    | not capturing, pixels discarded
//   CAPTURE | pixels packed into the buffer
//   DONE    | buffer full, pixels discarded until the next start

module pix_capture #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(DEPTH_WORDS * 4) + 1;
    localparam logic [CW-1:0] CAP_PIX = CW'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t         state;
    logic           done;
    logic [CW-1:0]  count;
    logic [1:0]     pix_idx;
    logic [23:0]    pack;
    logic [AW-1:0]  wptr;
    logic [31:0]    cksum;
    logic [31:0]    buf_mem [DEPTH_WORDS];
    logic [31:0]    rd_val;

    logic [11:0] off;
    logic        sel, bus_acc, ctrl_wr, do_abort, do_start;
    logic        pix_acc, cap_acc, word_we, last_word;
    logic [8:0]  buf_idx;
    logic        buf_hit;
    logic        unused_ok;

    assign off       = mem_addr[11:0];
    assign sel       = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]);
    // A request held through its ack cycle is not acknowledged twice.
    assign bus_acc   = sel && !mem_ready;
    assign ctrl_wr   = bus_acc && (off == 12'h000) && mem_wstrb[0];
    assign do_abort  = ctrl_wr && mem_wdata[1];
    assign do_start  = ctrl_wr && mem_wdata[0] && !mem_wdata[1];

    // Pixel handshake is judged against the state before any same-cycle CTRL write.
    assign pix_acc   = in_valid && in_ready;
    assign cap_acc   = pix_acc && (state == CAPTURE);
    assign word_we   = cap_acc && (pix_idx == 2'd3);
    assign last_word = (wptr == AW'(DEPTH_WORDS - 1));

    assign buf_idx   = off[10:2];
    assign buf_hit   = off[11] && ({1'b0, buf_idx} < 10'(DEPTH_WORDS));
    assign unused_ok = ^mem_wdata[31:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            count    <= '0;
            pix_idx  <= '0;
            pack     <= '0;
            wptr     <= '0;
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            // Count keeps the pixel that arrives alongside an abort.
            if (do_start) begin
                count <= '0;
            end else if (cap_acc && (count != CAP_PIX)) begin
                count <= count + 1'b1;
            end
            if (do_abort) begin
                state   <= IDLE;
                done    <= 1'b0;
                pix_idx <= '0;
                wptr    <= '0;
            end else if (do_start) begin
                state   <= CAPTURE;
                done    <= 1'b0;
                pix_idx <= '0;
                wptr    <= '0;
            end else if (cap_acc) begin
                pix_idx <= pix_idx + 1'b1;
                if (pix_idx != 2'd3) begin
                    pack[8*pix_idx +: 8] <= in_data;
                end else begin
                    wptr <= wptr + 1'b1;
                    if (last_word) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

    // Buffer is never cleared; stale words remain until overwritten.
    always_ff @(posedge clk) begin
        if (word_we) begin
            buf_mem[wptr] <= {in_data, pack};
        end
    end

`ifdef PIX_CAPTURE_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum <= '0;
        end else if (do_abort || do_start) begin
            cksum <= '0;
        end else if (cap_acc) begin
            cksum <= cksum + 32'(in_data);
        end
    end
`else
    assign cksum = '0;
`endif

    always_comb begin
        rd_val = '0;
        if (off[11]) begin
            if (buf_hit) begin
                rd_val = buf_mem[buf_idx[AW-1:0]];
            end
        end else begin
            case (off)
                12'h004: rd_val = {30'b0, done, (state == CAPTURE)};
                12'h008: rd_val = 32'(count);
                12'h00C: rd_val = cksum;
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= bus_acc;
            mem_rdata <= (bus_acc && (mem_wstrb == 4'h0)) ? rd_val : '0;
        end
    end

endmodule
